// File: rtl/pcs_tx_pause_sched.sv
// MAC->PCS TX scheduler: paces 32-bit XGMII words into 64b blocks, inserts gearbox
// pauses every PAUSE_PERIOD blocks and back-pressures the MAC on scrambler stalls.
module pcs_tx_pause_sched #(
  parameter int PAUSE_PERIOD = 32,
  parameter int PAUSE_LEN    = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_xgmii_valid,
  input  logic                 i_scrambler_rdy,
  output logic                 o_xgmii_pause,
  output logic                 o_encoder_en,
  output logic                 o_word_phase,
  output logic                 o_hdr_valid,
  output logic [5:0]           o_gearbox_seq,
  output logic                 o_protocol_err,
  output logic [CNT_WIDTH-1:0] o_blk_count
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    PAUSE    = 2'd2
  } state_t;

  localparam int             PCW       = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;
  localparam logic [5:0]     SEQ_LAST  = 6'(PAUSE_PERIOD - 1);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PAUSE_LEN - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic                   phase;
  logic [5:0]             seq;
  logic [PCW-1:0]         pcnt;
  logic                   pause_r;
  logic                   pause_nxt;
  logic                   err;
  logic [CNT_WIDTH-1:0]   blk;
  logic                   accept;
  logic                   blk_done;
  logic                   seq_wrap;

  assign accept   = i_xgmii_valid & i_scrambler_rdy & (state == RUN);
  assign blk_done = accept & phase;
  assign seq_wrap = blk_done & (seq == SEQ_LAST);

  // Disabling is deferred while a block is half-sent; a gearbox wrap takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      DISABLED: begin
        if (i_enable) state_nxt = RUN;
      end
      RUN: begin
        if (seq_wrap)
          state_nxt = PAUSE;
        else if (!i_enable && (blk_done || (!phase && !accept)))
          state_nxt = DISABLED;
      end
      PAUSE: begin
        if (pcnt == PCNT_LAST) state_nxt = i_enable ? RUN : DISABLED;
      end
      default: state_nxt = DISABLED;
    endcase
    pause_nxt = (state_nxt != RUN) | ~i_scrambler_rdy;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= DISABLED;
      phase   <= 1'b0;
      seq     <= '0;
      pcnt    <= '0;
      pause_r <= 1'b1;
      err     <= 1'b0;
      blk     <= '0;
    end else begin
      state   <= state_nxt;
      pause_r <= pause_nxt;
      pcnt    <= (state == PAUSE) ? pcnt + PCW'(1) : '0;
      if (accept) phase <= ~phase;
      if (blk_done) begin
        blk <= blk + CNT_WIDTH'(1);
        seq <= seq_wrap ? 6'd0 : seq + 6'd1;
      end
      if ((state == PAUSE) && i_xgmii_valid) err <= 1'b1;
    end
  end

  assign o_xgmii_pause  = pause_r;
  assign o_encoder_en   = accept;
  assign o_word_phase   = phase;
  assign o_hdr_valid    = accept & ~phase;
  assign o_gearbox_seq  = seq;
  assign o_protocol_err = err;
  assign o_blk_count    = blk;

endmodule

// File: tb/tb_pcs_tx_pause_sched.sv
// Bench for pcs_tx_pause_sched: scoreboard of accepted words plus directed checks of
// pause, error, reset and a short-period instance.
module tb_pcs_tx_pause_sched;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_enable, i_xgmii_valid, i_scrambler_rdy;
  logic        o_xgmii_pause, o_encoder_en, o_word_phase, o_hdr_valid, o_protocol_err;
  logic [5:0]  o_gearbox_seq;
  logic [31:0] o_blk_count;

  logic        e4, v4, r4;
  logic        pause4, en4, phase4, hdr4, err4;
  logic [5:0]  seq4;
  logic [2:0]  blk4;

  typedef struct packed {
    logic        phase;
    logic        hdr;
    logic [5:0]  seq;
    logic [31:0] blk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 i_clk = ~i_clk;

  pcs_tx_pause_sched #(.PAUSE_PERIOD(32), .PAUSE_LEN(2), .CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_xgmii_valid(i_xgmii_valid), .i_scrambler_rdy(i_scrambler_rdy),
    .o_xgmii_pause(o_xgmii_pause), .o_encoder_en(o_encoder_en),
    .o_word_phase(o_word_phase), .o_hdr_valid(o_hdr_valid),
    .o_gearbox_seq(o_gearbox_seq), .o_protocol_err(o_protocol_err),
    .o_blk_count(o_blk_count)
  );

  pcs_tx_pause_sched #(.PAUSE_PERIOD(4), .PAUSE_LEN(2), .CNT_WIDTH(3)) dut4 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(e4),
    .i_xgmii_valid(v4), .i_scrambler_rdy(r4),
    .o_xgmii_pause(pause4), .o_encoder_en(en4),
    .o_word_phase(phase4), .o_hdr_valid(hdr4),
    .o_gearbox_seq(seq4), .o_protocol_err(err4),
    .o_blk_count(blk4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectWord(input logic ph, input int sq, input int bk);
    exp_t e;
    e.phase = ph;
    e.hdr   = ~ph;
    e.seq   = 6'(sq);
    e.blk   = 32'(bk);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic e);
    i_xgmii_valid   = v;
    i_scrambler_rdy = r;
    i_enable        = e;
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every accepted word must match the next queued expectation.
  always @(negedge i_clk) begin
    if (o_encoder_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_accept: got en=1, expected en=0 (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("word_phase", 32'(o_word_phase), 32'(mon_e.phase));
        checkOutput("hdr_valid", 32'(o_hdr_valid), 32'(mon_e.hdr));
        checkOutput("gearbox_seq", 32'(o_gearbox_seq), 32'(mon_e.seq));
        checkOutput("blk_count", o_blk_count, mon_e.blk);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    i_reset_n = 1'b1;
    i_enable = 1'b0; i_xgmii_valid = 1'b0; i_scrambler_rdy = 1'b1;
    e4 = 1'b0; v4 = 1'b0; r4 = 1'b1;
    #1 i_reset_n = 1'b0;
    #1;
    checkOutput("rst_pause", 32'(o_xgmii_pause), 32'd1);
    checkOutput("rst_en", 32'(o_encoder_en), 32'd0);
    checkOutput("rst_phase", 32'(o_word_phase), 32'd0);
    checkOutput("rst_seq", 32'(o_gearbox_seq), 32'd0);
    checkOutput("rst_blk", o_blk_count, 32'd0);
    checkOutput("rst_err", 32'(o_protocol_err), 32'd0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // T1: 64 back-to-back words fill one gearbox cycle
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t1_run_pause", 32'(o_xgmii_pause), 32'd0);
    for (int i = 0; i < 64; i++) begin
      expectWord(i[0], i / 2, i / 2);
      applyStimulus(1'b1, 1'b1, 1'b1);
    end
    checkOutput("t1_pause_start", 32'(o_xgmii_pause), 32'd1);
    checkOutput("t1_seq_wrap", 32'(o_gearbox_seq), 32'd0);
    checkOutput("t1_blk", o_blk_count, 32'd32);
    checkOutput("t1_err_before", 32'(o_protocol_err), 32'd0);
    checkOutput("t1_drained", 32'(exp_q.size()), 32'd0);

    // T2: MAC keeps valid high through the pause; a scrambler stall must not stretch it
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t2_pause_cyc2", 32'(o_xgmii_pause), 32'd1);
    checkOutput("t2_err_set", 32'(o_protocol_err), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t2_pause_end", 32'(o_xgmii_pause), 32'd0);
    checkOutput("t2_err_sticky", 32'(o_protocol_err), 32'd1);

    // T3: scrambler stall mid-block
    expectWord(1'b0, 0, 32);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t3_phase_after_p0", 32'(o_word_phase), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("t3_stall_pause", 32'(o_xgmii_pause), 32'd1);
      checkOutput("t3_stall_phase", 32'(o_word_phase), 32'd1);
    end
    expectWord(1'b1, 0, 32);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t3_pause_release", 32'(o_xgmii_pause), 32'd0);
    checkOutput("t3_blk", o_blk_count, 32'd33);
    checkOutput("t3_seq", 32'(o_gearbox_seq), 32'd1);
    checkOutput("t3_err_sticky", 32'(o_protocol_err), 32'd1);
    checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with a partial block in flight
    expectWord(1'b0, 1, 33);
    applyStimulus(1'b1, 1'b1, 1'b1);
    i_xgmii_valid = 1'b0; i_enable = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    checkOutput("arst_phase", 32'(o_word_phase), 32'd0);
    checkOutput("arst_seq", 32'(o_gearbox_seq), 32'd0);
    checkOutput("arst_blk", o_blk_count, 32'd0);
    checkOutput("arst_err", 32'(o_protocol_err), 32'd0);
    checkOutput("arst_pause", 32'(o_xgmii_pause), 32'd1);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // Enable dropped at phase 0 with no word pending
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle_run_pause", 32'(o_xgmii_pause), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("idle_disable_pause", 32'(o_xgmii_pause), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle_reenable", 32'(o_xgmii_pause), 32'd0);

    // T4: enable drops after a phase-0 word; block still completes
    expectWord(1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    expectWord(1'b1, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4_pause", 32'(o_xgmii_pause), 32'd1);
    checkOutput("t4_blk", o_blk_count, 32'd1);
    checkOutput("t4_seq", 32'(o_gearbox_seq), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4_err_clear", 32'(o_protocol_err), 32'd0);
    checkOutput("t4_still_paused", 32'(o_xgmii_pause), 32'd1);
    checkOutput("t4_blk_held", o_blk_count, 32'd1);
    checkOutput("t4_drained", 32'(exp_q.size()), 32'd0);

    // T5: reset asserted mid-PAUSE
    i_reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    i_reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 64; i++) begin
      expectWord(i[0], i / 2, i / 2);
      applyStimulus(1'b1, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_err_pre", 32'(o_protocol_err), 32'd1);
    checkOutput("t5_blk_pre", o_blk_count, 32'd32);
    i_xgmii_valid = 1'b0; i_enable = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    checkOutput("t5_pause", 32'(o_xgmii_pause), 32'd1);
    checkOutput("t5_seq", 32'(o_gearbox_seq), 32'd0);
    checkOutput("t5_phase", 32'(o_word_phase), 32'd0);
    checkOutput("t5_blk", o_blk_count, 32'd0);
    checkOutput("t5_err", 32'(o_protocol_err), 32'd0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t5_stays_disabled", 32'(o_xgmii_pause), 32'd1);
    checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);
    i_xgmii_valid = 1'b0;

    // T6: short gearbox cycle, 3-bit block counter wraps twice
    e4 = 1'b1; r4 = 1'b1; v4 = 1'b0;
    @(posedge i_clk); #1;
    for (int k = 0; k < 40; k++) begin
      v4 = 1'b1;
      @(negedge i_clk);
      checkOutput("t6_en", 32'(en4), ((k % 10) < 8) ? 32'd1 : 32'd0);
      checkOutput("t6_pause", 32'(pause4), ((k % 10) >= 8) ? 32'd1 : 32'd0);
      if ((k % 10) < 8) begin
        checkOutput("t6_phase", 32'(phase4), 32'((k % 10) % 2));
        checkOutput("t6_seq", 32'(seq4), 32'((k % 10) / 2));
        checkOutput("t6_blk", 32'(blk4), 32'((4 * (k / 10) + (k % 10) / 2) % 8));
      end
      @(posedge i_clk); #1;
    end
    v4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
